power_fault_monitor: RTL
========================

Name: power_fault_monitor

Overview:
- Generates the shutdown vector consumed by the GPIO power-management stage.
- Monitors battery voltage samples from the ADC interface for sustained undervoltage, and monitors a controller heartbeat through a watchdog.
- Each fault source drives one shutdown bit; faults latch until software clears them.

Parameters:
- ADC_WIDTH, 12, width of voltage sample.
- LOW_THRESH, 2048, a sample strictly below this value counts as low.
- RECOVER_THRESH, 2200, a sample at or above this value counts as recovered (hysteresis band is [LOW_THRESH, RECOVER_THRESH)).
- DEBOUNCE_SAMPLES, 8, consecutive low samples required to trip (>=1).
- WDOG_CYCLES, 50000000, clock cycles without heartbeat before watchdog trip (1 s at 50 MHz).
- WDOG_WIDTH, 26, watchdog counter width; must hold WDOG_CYCLES-1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe, sample is valid
- sample  in  ADC_WIDTH  unsigned battery voltage code
- heartbeat  in  1  one-cycle pulse from controller, kicks watchdog
- clear  in  1  one-cycle pulse, request to clear latched faults
- shutdown  out  2  bit0 undervoltage, bit1 watchdog; feeds downstream shutdown input
- uv_state  out  2  current undervoltage FSM state (status register)
- low_count  out  4  current consecutive-low count (status)

Behaviour:
- One clock; reset is asynchronous and active-low. All state is registered on posedge clk.
- Reset values: uv_state=INIT, shutdown=2'b01, low_count=0, watchdog counter=0, recovered flag=0.
- Undervoltage FSM, encoding INIT=0, OK=1, PENDING=2, TRIPPED=3:
  - INIT: shutdown[0]=1. A valid sample >= RECOVER_THRESH moves to OK; no clear is needed. Other samples keep INIT.
  - OK: shutdown[0]=0. A valid sample < LOW_THRESH sets low_count=1 and moves to PENDING; if DEBOUNCE_SAMPLES=1, it moves directly to TRIPPED.
  - PENDING: a valid low sample increments low_count. Reaching DEBOUNCE_SAMPLES moves to TRIPPED. A valid sample >= LOW_THRESH sets low_count=0 and returns to OK.
  - TRIPPED: shutdown[0]=1 and low_count holds. Exits to OK, with low_count=0, only when clear=1 and the recovered flag=1.
- Recovered flag: set by a valid sample >= RECOVER_THRESH, cleared by a valid sample < RECOVER_THRESH, held otherwise.
- The flag update and the clear check use the registered flag. A clear arriving in the same cycle as the recovering sample is ignored.
- Latency: shutdown[0] rises on the clock edge that registers the DEBOUNCE_SAMPLES-th low sample. It is visible one cycle after that sample's strobe.
- Cycles without sample_valid do not change the count.
- Watchdog:
  - The counter increments every cycle.
  - heartbeat=1 resets it to 0 and has priority over terminal count in the same cycle.
  - Reaching WDOG_CYCLES-1 without heartbeat sets shutdown[1]=1 and stops the counter.
  - clear=1 while latched resets shutdown[1]=0 and the counter to 0.
  - shutdown[1] is 0 after reset.
- Simultaneous events:
  - A trip condition and clear in the same cycle: the trip wins, for both bits.
  - heartbeat during a latched watchdog fault does not clear it; only clear does.
- Reset asserted mid-operation immediately forces the reset values, including shutdown=2'b01.
- The counter saturates and never wraps.

Decomposition:
- Package power_pkg holds:
  - the uv_state encoding constants;
  - shutdown bit indices SD_UNDERVOLT=0 and SD_WATCHDOG=1;
  - NUM_SHUTDOWN=2, used to size the downstream shutdown input.
- Sub-module watchdog_timer (parameters WDOG_CYCLES, WDOG_WIDTH) holds the watchdog logic. Ports: clk, reset_n, kick, clear, expired.
- The undervoltage FSM stays in the top module.

Test Plan:
- Reset, then sample 2300 valid -> uv_state INIT->OK, shutdown=2'b00. Before that sample, shutdown=2'b01.
- In OK, send 8 samples of 2000 on consecutive strobes, with idle cycles between -> shutdown[0]=1 one cycle after the 8th strobe; low_count=8.
- In OK, send 7 samples of 2000, then 2100, then 7 samples of 2000 -> no trip; low_count returns to 0 at the 2100 sample.
- In TRIPPED, send sample 2100 then clear -> stays TRIPPED. Then send 2200, and clear on a later cycle -> OK, shutdown[0]=0.
- With WDOG_CYCLES=16, no heartbeat -> shutdown[1]=1 after 15 cycles. heartbeat at cycle 14 instead -> no trip. clear -> shutdown[1]=0 and the count restarts.
- Assert reset_n=0 while TRIPPED with the watchdog latched -> shutdown=2'b01 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/power_pkg.sv
// Shared definitions for the power fault monitor: undervoltage state
// encoding (also exported on the status port) and shutdown bit layout.
package power_pkg;

  typedef enum logic [1:0] {
    UV_INIT    = 2'd0,
    UV_OK      = 2'd1,
    UV_PENDING = 2'd2,
    UV_TRIPPED = 2'd3
  } uv_state_t;

  localparam int SD_UNDERVOLT = 0;
  localparam int SD_WATCHDOG  = 1;
  localparam int NUM_SHUTDOWN = 2;

endpackage

// File: rtl/watchdog_timer.sv
// Heartbeat watchdog: counts cycles since the last kick and latches
// "expired" when the count reaches WDOG_CYCLES-1. The counter freezes
// while latched; only clear releases the latch (kick does not).
module watchdog_timer #(
  parameter int WDOG_CYCLES = 50000000,
  parameter int WDOG_WIDTH  = 26
) (
  input  logic clk,
  input  logic reset_n,
  input  logic kick,
  input  logic clear,
  output logic expired
);

  localparam logic [WDOG_WIDTH-1:0] LAST = WDOG_WIDTH'(WDOG_CYCLES - 1);
  localparam logic [WDOG_WIDTH-1:0] ONE  = WDOG_WIDTH'(1);

  logic [WDOG_WIDTH-1:0] count;
  logic [WDOG_WIDTH-1:0] count_inc;

  assign count_inc = count + ONE;

  // Counter and latch; the latch is set on the edge the counter lands on
  // LAST, and a clear cannot race a trip because clear only acts when latched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (expired) begin
      if (clear) begin
        count   <= '0;
        expired <= 1'b0;
      end
    end else if (kick) begin
      count <= '0;
    end else if (count == LAST) begin
      expired <= 1'b1;
    end else begin
      count <= count_inc;
      if (count_inc == LAST) expired <= 1'b1;
    end
  end

endmodule

// File: rtl/power_fault_monitor.sv
// Power fault monitor: debounced battery undervoltage FSM with hysteresis
// plus a heartbeat watchdog, each driving one latched shutdown bit.
module power_fault_monitor
  import power_pkg::*;
#(
  parameter int ADC_WIDTH        = 12,
  parameter int LOW_THRESH       = 2048,
  parameter int RECOVER_THRESH   = 2200,
  parameter int DEBOUNCE_SAMPLES = 8,
  parameter int WDOG_CYCLES      = 50000000,
  parameter int WDOG_WIDTH       = 26
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_valid,
  input  logic [ADC_WIDTH-1:0]    sample,
  input  logic                    heartbeat,
  input  logic                    clear,
  output logic [NUM_SHUTDOWN-1:0] shutdown,
  output logic [1:0]              uv_state,
  output logic [3:0]              low_count
);

  localparam logic [ADC_WIDTH-1:0] LOW_T = ADC_WIDTH'(LOW_THRESH);
  localparam logic [ADC_WIDTH-1:0] REC_T = ADC_WIDTH'(RECOVER_THRESH);
  localparam logic [3:0]           DEB_T = 4'(DEBOUNCE_SAMPLES);

  uv_state_t  state;
  uv_state_t  state_next;
  logic [3:0] low_count_next;
  logic       recovered;
  logic       recovered_next;
  logic       is_low;
  logic [3:0] low_count_inc;
  logic       wdog_expired;

  assign is_low        = sample_valid && (sample < LOW_T);
  assign low_count_inc = low_count + 4'd1;

  // Next-state, debounce count and hysteresis flag; clear is qualified by
  // the registered flag so a recovering sample cannot also release a trip.
  always_comb begin
    state_next     = state;
    low_count_next = low_count;
    recovered_next = recovered;
    if (sample_valid) recovered_next = (sample >= REC_T);
    case (state)
      UV_INIT: begin
        if (sample_valid && (sample >= REC_T)) state_next = UV_OK;
      end
      UV_OK: begin
        if (is_low) begin
          low_count_next = 4'd1;
          state_next     = (DEB_T == 4'd1) ? UV_TRIPPED : UV_PENDING;
        end
      end
      UV_PENDING: begin
        if (is_low) begin
          low_count_next = low_count_inc;
          if (low_count_inc == DEB_T) state_next = UV_TRIPPED;
        end else if (sample_valid) begin
          low_count_next = 4'd0;
          state_next     = UV_OK;
        end
      end
      UV_TRIPPED: begin
        if (clear && recovered) begin
          low_count_next = 4'd0;
          state_next     = UV_OK;
        end
      end
      default: state_next = UV_INIT;
    endcase
  end

  // Undervoltage state registers; reset lands in INIT which asserts shutdown.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= UV_INIT;
      low_count <= 4'd0;
      recovered <= 1'b0;
    end else begin
      state     <= state_next;
      low_count <= low_count_next;
      recovered <= recovered_next;
    end
  end

  watchdog_timer #(
    .WDOG_CYCLES(WDOG_CYCLES),
    .WDOG_WIDTH (WDOG_WIDTH)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .kick   (heartbeat),
    .clear  (clear),
    .expired(wdog_expired)
  );

  // Shutdown bits decode directly from registered state, so reset forces
  // 2'b01 asynchronously without waiting for a clock edge.
  assign shutdown[SD_UNDERVOLT] = (state == UV_INIT) || (state == UV_TRIPPED);
  assign shutdown[SD_WATCHDOG]  = wdog_expired;
  assign uv_state               = state;

endmodule
